// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch stage's control inputs, its instruction-memory
// port and its IF/ID outputs.
//   master : the fetch stage (drives pc, imem_addr, IF/ID, status)
//   slave  : the surrounding pipeline / memory (drives control and imem_dout)
interface fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
);
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              jump;
  logic [31:0]       jump_target;
  logic              halt;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_dout;
  logic [31:0]       pc;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc4;
  logic              if_id_valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              halted;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, halt, imem_dout,
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, misalign_err,
           fetch_cnt, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, halt, imem_dout,
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, misalign_err,
           fetch_cnt, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Owns the PC, addresses the
// instruction memory and loads the IF/ID register; handles stall, jump/branch
// redirect with flush, halt, a sticky misaligned-target flag and a saturating
// fetch counter.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : fetch_if.master (control in, imem port, IF/ID and status out)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q;
  logic [31:0]      redirect_tgt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values; everything holds unless RUN acts
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    mis_d        = mis_q;
    cnt_d        = cnt_q;
    redirect_tgt = bus.jump ? bus.jump_target : bus.branch_target;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
          instr_d = 32'h0;
        end else if (bus.jump || bus.branch_taken) begin
          // Redirect beats stall: the wrong-path fetch is squashed regardless
          pc_d    = {redirect_tgt[31:2], 2'b00};
          valid_d = 1'b0;
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          if (redirect_tgt[1:0] != 2'b00) mis_d = 1'b1;
        end else if (!bus.stall) begin
          instr_d = bus.imem_dout;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc4_q    <= 32'h0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Word address wraps naturally by truncation to ADDR_W bits
  assign bus.imem_addr    = pc_q[ADDR_W+1:2];
  assign bus.pc           = pc_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.misalign_err = mis_q;
  assign bus.fetch_cnt    = cnt_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives two fetch_stage instances (default build, and one with
// RESET_PC=0xFFC / CNT_W=4) from shared stimulus and compares every output each
// cycle against a behavioural model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall, branch_taken, jump, halt;
  logic [31:0] branch_target, jump_target;
  logic [31:0] mem [1024];

  int unsigned vectors;
  int unsigned miscompares;

  fetch_if #(.ADDR_W(10), .CNT_W(16)) if_a ();
  fetch_if #(.ADDR_W(10), .CNT_W(4))  if_b ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(10), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.master));
  fetch_stage #(.RESET_PC(32'h0000_0FFC), .ADDR_W(10), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.master));

  assign if_a.stall = stall;         assign if_b.stall = stall;
  assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken;
  assign if_a.branch_target = branch_target; assign if_b.branch_target = branch_target;
  assign if_a.jump = jump;           assign if_b.jump = jump;
  assign if_a.jump_target = jump_target; assign if_b.jump_target = jump_target;
  assign if_a.halt = halt;           assign if_b.halt = halt;
  assign if_a.imem_dout = mem[if_a.imem_addr];
  assign if_b.imem_dout = mem[if_b.imem_addr];

  // Observed outputs gathered per instance
  logic [31:0] o_pc[2], o_addr[2], o_instr[2], o_pc4[2], o_cnt[2];
  logic        o_valid[2], o_mis[2], o_halted[2];
  assign o_pc[0] = if_a.pc;            assign o_pc[1] = if_b.pc;
  assign o_addr[0] = 32'(if_a.imem_addr); assign o_addr[1] = 32'(if_b.imem_addr);
  assign o_instr[0] = if_a.if_id_instr; assign o_instr[1] = if_b.if_id_instr;
  assign o_pc4[0] = if_a.if_id_pc4;    assign o_pc4[1] = if_b.if_id_pc4;
  assign o_cnt[0] = 32'(if_a.fetch_cnt); assign o_cnt[1] = 32'(if_b.fetch_cnt);
  assign o_valid[0] = if_a.if_id_valid; assign o_valid[1] = if_b.if_id_valid;
  assign o_mis[0] = if_a.misalign_err; assign o_mis[1] = if_b.misalign_err;
  assign o_halted[0] = if_a.halted;    assign o_halted[1] = if_b.halted;

  // Reference model: phase 0 = first cycle after reset, 1 = fetching, 2 = halted
  logic [31:0] m_pc[2], m_instr[2], m_pc4[2], m_cnt[2];
  logic        m_valid[2], m_mis[2];
  int          m_phase[2];
  logic [31:0] reset_pc[2];
  logic [31:0] cnt_max[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = reset_pc[k]; m_instr[k] = 32'h0; m_pc4[k] = 32'h0;
        m_valid[k] = 1'b0; m_mis[k] = 1'b0; m_cnt[k] = 32'h0; m_phase[k] = 0;
      end else if (m_phase[k] == 0) begin
        m_phase[k] = 1;
      end else if (m_phase[k] == 1) begin
        if (halt) begin
          m_phase[k] = 2; m_valid[k] = 1'b0; m_instr[k] = 32'h0;
        end else if (jump || branch_taken) begin
          tgt = jump ? jump_target : branch_target;
          m_pc[k] = tgt & 32'hFFFF_FFFC;
          m_valid[k] = 1'b0; m_instr[k] = 32'h0; m_pc4[k] = 32'h0;
          if ((tgt & 32'h3) != 0) m_mis[k] = 1'b1;
        end else if (!stall) begin
          m_instr[k] = mem[(m_pc[k] / 4) % 1024];
          m_pc4[k]   = m_pc[k] + 32'd4;
          m_valid[k] = 1'b1;
          m_pc[k]    = m_pc[k] + 32'd4;
          if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("pc[%0d]", k), o_pc[k], m_pc[k]);
      check_eq($sformatf("imem_addr[%0d]", k), o_addr[k], (m_pc[k] / 4) % 1024);
      check_eq($sformatf("if_id_instr[%0d]", k), o_instr[k], m_instr[k]);
      check_eq($sformatf("if_id_pc4[%0d]", k), o_pc4[k], m_pc4[k]);
      check_eq($sformatf("if_id_valid[%0d]", k), 32'(o_valid[k]), 32'(m_valid[k]));
      check_eq($sformatf("misalign_err[%0d]", k), 32'(o_mis[k]), 32'(m_mis[k]));
      check_eq($sformatf("fetch_cnt[%0d]", k), o_cnt[k], m_cnt[k]);
      check_eq($sformatf("halted[%0d]", k), 32'(o_halted[k]), (m_phase[k] == 2) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  initial begin
    logic [31:0] held_pc;
    vectors = 0; miscompares = 0;
    reset_pc[0] = 32'h0;  reset_pc[1] = 32'h0000_0FFC;
    cnt_max[0]  = 32'd65535; cnt_max[1] = 32'd15;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_instr[k] = 32'h0; m_pc4[k] = 32'h0; m_cnt[k] = 32'h0;
      m_valid[k] = 1'b0; m_mis[k] = 1'b0; m_phase[k] = 0;
    end
    idle_inputs();

    // Reset, boot cycle, first fetches
    reset = 1'b1;
    @(negedge clk);
    step(); step();
    check_eq("rst_pc_a", o_pc[0], 32'h0);
    check_eq("rst_addr_b", o_addr[1], 32'd1023);
    reset = 1'b0;
    step();
    check_eq("boot_valid", 32'(o_valid[0]), 32'd0);
    check_eq("boot_pc", o_pc[0], 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("fetch_pc4", o_pc4[0], 32'(4 * i));
      check_eq("fetch_valid", 32'(o_valid[0]), 32'd1);
      if (i == 1) check_eq("wrap_addr_b", o_addr[1], 32'd0);
    end

    // Stall holds pc, IF/ID and counter
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_pc", o_pc[0], 32'hC);
      check_eq("stall_cnt", o_cnt[0], 32'd3);
      check_eq("stall_instr", o_instr[0], mem[2]);
    end
    stall = 1'b0;
    step();
    check_eq("resume_pc", o_pc[0], 32'h10);

    // Redirect beats stall; jump beats branch
    branch_taken = 1'b1; branch_target = 32'h800; stall = 1'b1;
    step();
    check_eq("br_pc", o_pc[0], 32'h800);
    check_eq("br_addr", o_addr[0], 32'd512);
    check_eq("br_valid", 32'(o_valid[0]), 32'd0);
    stall = 1'b0; jump = 1'b1; jump_target = 32'h40;
    step();
    check_eq("jmp_pc", o_pc[0], 32'h40);

    // Misaligned target sets sticky error
    idle_inputs();
    jump = 1'b1; jump_target = 32'h102;
    step();
    check_eq("mis_pc", o_pc[0], 32'h100);
    check_eq("mis_set", 32'(o_mis[0]), 32'd1);
    idle_inputs();
    for (int i = 0; i < 20; i++) step();
    check_eq("mis_sticky", 32'(o_mis[0]), 32'd1);
    check_eq("cnt_sat_b", o_cnt[1], 32'd15);

    // Halt freezes everything until reset
    halt = 1'b1;
    step();
    check_eq("halt_flag", 32'(o_halted[0]), 32'd1);
    check_eq("halt_valid", 32'(o_valid[0]), 32'd0);
    held_pc = o_pc[0];
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      jump = i[0]; jump_target = 32'h200; stall = ~i[0];
      step();
      check_eq("halt_pc", o_pc[0], held_pc);
    end
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_eq("post_halt_boot", 32'(o_halted[0]) | (32'(o_valid[0]) << 1), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) < 2);
      halt          = ($urandom_range(0, 99) < 2);
      stall         = ($urandom_range(0, 99) < 25);
      branch_taken  = ($urandom_range(0, 99) < 10);
      jump          = ($urandom_range(0, 99) < 5);
      branch_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_1FFC);
      jump_target   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_1FFC);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
